// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ sequencer: icodes, status codes,
// stage-state encoding and the memory-stage classifier.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPDATE,
      S_HALT
   } stage_e;

   // True for instructions that read or write data memory.
   function automatic logic needs_mem(input logic [3:0] icode);
      return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
   endfunction

endpackage

// File: rtl/y86_mem_watchdog.sv
// Data-memory wait counter: clears while idle, counts MEMORY cycles and flags
// the last allowed cycle. MEM_TIMEOUT of 0 disables expiry.
module y86_mem_watchdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/y86_seq_sequencer.sv
// Multi-cycle stage controller for the Y86-64 SEQ datapath.
// Define Y86_SEQ_PERF_EN to build the retired-instruction counter.
module y86_seq_sequencer
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic             dmem_ack,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             memory_en,
   output logic             dmem_req,
   output logic             writeback_en,
   output logic             pc_update_en,
   output logic [2:0]       stat,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   stage_e     state_q, state_d;
   logic [2:0] stat_q, stat_d;
   logic [3:0] icode_q, icode_d;
   logic       wd_expired;

   y86_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q != S_MEMORY),
      .inc    (state_q == S_MEMORY),
      .expired(wd_expired)
   );

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      icode_d = icode_q;
      case (state_q)
         S_FETCH: begin
            if (imem_error) begin
               stat_d  = SADR;
               state_d = S_HALT;
            end else if (!instr_valid) begin
               stat_d  = SINS;
               state_d = S_HALT;
            end else if (icode == IHALT) begin
               stat_d  = SHLT;
               state_d = S_HALT;
            end else begin
               icode_d = icode;
               state_d = S_DECODE;
            end
         end
         S_DECODE:    state_d = S_EXECUTE;
         S_EXECUTE:   state_d = needs_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
         S_MEMORY: begin
            // A faulting ack or a timeout both end the instruction without writeback.
            if (dmem_ack && dmem_error) begin
               stat_d  = SADR;
               state_d = S_HALT;
            end else if (dmem_ack) begin
               state_d = S_WRITEBACK;
            end else if (wd_expired) begin
               stat_d  = SADR;
               state_d = S_HALT;
            end
         end
         S_WRITEBACK: state_d = S_PCUPDATE;
         S_PCUPDATE:  state_d = S_FETCH;
         default:     state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: only control state is reset; icode_q is always loaded in FETCH before use.
      if (reset) begin
         state_q <= S_FETCH;
         stat_q  <= SAOK;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
      end
      icode_q <= icode_d;
   end

   // Enables are forced low while reset is asserted.
   assign fetch_en     = !reset && (state_q == S_FETCH);
   assign decode_en    = !reset && (state_q == S_DECODE);
   assign execute_en   = !reset && (state_q == S_EXECUTE);
   assign memory_en    = !reset && (state_q == S_MEMORY);
   assign dmem_req     = memory_en;
   assign writeback_en = !reset && (state_q == S_WRITEBACK);
   assign pc_update_en = !reset && (state_q == S_PCUPDATE);
   assign halted       = !reset && (state_q == S_HALT);
   assign stat         = reset ? SAOK : stat_q;

`ifdef Y86_SEQ_PERF_EN
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (state_q == S_PCUPDATE)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign instr_count = count_q;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Directed self-checking bench for y86_seq_sequencer.
module tb_y86_seq_sequencer;

   localparam int CNT_W = 32;

   localparam logic [6:0] EN_0 = 7'b0000000;
   localparam logic [6:0] EN_F = 7'b1000000;
   localparam logic [6:0] EN_D = 7'b0100000;
   localparam logic [6:0] EN_E = 7'b0010000;
   localparam logic [6:0] EN_M = 7'b0001100;
   localparam logic [6:0] EN_W = 7'b0000010;
   localparam logic [6:0] EN_P = 7'b0000001;

`ifdef Y86_SEQ_PERF_EN
   localparam logic [CNT_W-1:0] CNT_AFTER_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_AFTER_TWO = 2;
`else
   localparam logic [CNT_W-1:0] CNT_AFTER_ONE = 0;
   localparam logic [CNT_W-1:0] CNT_AFTER_TWO = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       icode;
   logic             instr_valid;
   logic             imem_error;
   logic             dmem_ack;
   logic             dmem_error;
   logic             fetch_en, decode_en, execute_en, memory_en, dmem_req;
   logic             writeback_en, pc_update_en, halted;
   logic [2:0]       stat;
   logic [CNT_W-1:0] instr_count;

   int checks = 0;
   int fails  = 0;

   y86_seq_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .dmem_ack    (dmem_ack),
      .dmem_error  (dmem_error),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .execute_en  (execute_en),
      .memory_en   (memory_en),
      .dmem_req    (dmem_req),
      .writeback_en(writeback_en),
      .pc_update_en(pc_update_en),
      .stat        (stat),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] enables();
      return {fetch_en, decode_en, execute_en, memory_en, dmem_req, writeback_en, pc_update_en};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0;
      dmem_ack = 1'b0; dmem_error = 1'b0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      logic [6:0] walk [5];
      walk[0] = EN_D; walk[1] = EN_E; walk[2] = EN_W; walk[3] = EN_P; walk[4] = EN_F;

      // Reset state, observed while reset is still high.
      reset = 1'b1; icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0;
      dmem_ack = 1'b0; dmem_error = 1'b0;
      tick(); tick();
      check("rst_en",     64'(enables()), 64'(EN_0));
      check("rst_stat",   64'(stat), 64'd1);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_cnt",    64'(instr_count), 64'd0);
      reset = 1'b0;
      #1;
      check("rst_fetch", 64'(enables()), 64'(EN_F));

      // Two irmovq; the second with stray dmem_ack/dmem_error that must be ignored.
      icode = 4'h3; instr_valid = 1'b1;
      for (int n = 0; n < 2; n++) begin
         dmem_ack = (n == 1); dmem_error = (n == 1);
         for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("irmovq%0d_s%0d", n, s), 64'(enables()), 64'(walk[s]));
         end
         check($sformatf("irmovq%0d_cnt", n), 64'(instr_count),
               64'((n == 0) ? CNT_AFTER_ONE : CNT_AFTER_TWO));
         check($sformatf("irmovq%0d_stat", n), 64'(stat), 64'd1);
      end
      dmem_ack = 1'b0; dmem_error = 1'b0;

      // mrmovq with three wait cycles: D E M M M M W P F.
      icode = 4'h5;
      tick(); check("mr_d", 64'(enables()), 64'(EN_D));
      tick(); check("mr_e", 64'(enables()), 64'(EN_E));
      for (int k = 0; k < 4; k++) begin
         tick(); check($sformatf("mr_m%0d", k), 64'(enables()), 64'(EN_M));
      end
      dmem_ack = 1'b1;
      tick(); check("mr_w", 64'(enables()), 64'(EN_W));
      dmem_ack = 1'b0;
      check("mr_stat", 64'(stat), 64'd1);
      tick(); check("mr_p", 64'(enables()), 64'(EN_P));
      tick(); check("mr_f", 64'(enables()), 64'(EN_F));

      // pushq with a faulting ack.
      icode = 4'hA;
      tick(); tick(); tick();
      check("push_m", 64'(enables()), 64'(EN_M));
      dmem_ack = 1'b1; dmem_error = 1'b1;
      tick();
      dmem_ack = 1'b0; dmem_error = 1'b0;
      check("push_halt_en", 64'(enables()), 64'(EN_0));
      check("push_stat",    64'(stat), 64'd3);
      check("push_halted",  64'(halted), 64'd1);
      tick(); tick();
      check("push_stay_en",  64'(enables()), 64'(EN_0));
      check("push_stay_hlt", 64'(halted), 64'd1);

      // rmmovq with no ack: 16 MEMORY cycles then ADR.
      do_reset();
      icode = 4'h4; instr_valid = 1'b1;
      tick(); tick(); tick();
      check("tmo_m1", 64'(dmem_req), 64'd1);
      for (int k = 2; k <= 16; k++) begin
         tick();
         check($sformatf("tmo_m%0d", k), 64'(dmem_req), 64'd1);
      end
      tick();
      check("tmo_stat",   64'(stat), 64'd3);
      check("tmo_halted", 64'(halted), 64'd1);
      check("tmo_req",    64'(dmem_req), 64'd0);

      // Fetch faults and their priority.
      do_reset();
      icode = 4'h3; imem_error = 1'b1; instr_valid = 1'b0;
      tick();
      check("ff_adr_stat", 64'(stat), 64'd3);
      check("ff_adr_en",   64'(enables()), 64'(EN_0));
      do_reset();
      icode = 4'h3; instr_valid = 1'b0;
      tick();
      check("ff_ins_stat", 64'(stat), 64'd4);
      do_reset();
      icode = 4'h0; instr_valid = 1'b1;
      tick();
      check("ff_hlt_stat", 64'(stat), 64'd2);
      tick();
      check("ff_hlt_en",     64'(enables()), 64'(EN_0));
      check("ff_hlt_halted", 64'(halted), 64'd1);

      // Reset during the second MEMORY wait cycle.
      do_reset();
      icode = 4'h5; instr_valid = 1'b1;
      tick(); tick(); tick(); tick();
      check("rm_m2", 64'(enables()), 64'(EN_M));
      reset = 1'b1;
      #1;
      check("rm_req_during", 64'(dmem_req), 64'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rm_fetch", 64'(enables()), 64'(EN_F));
      check("rm_stat",  64'(stat), 64'd1);
      check("rm_cnt",   64'(instr_count), 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
